// File: rtl/harris_pkg.sv
// rtl/harris_pkg.sv - shared widths, FSM states and result record for the Harris corner pipeline
package harris_pkg;

  localparam int FEATURE_W = 54;
  localparam int COORD_W   = 10;
  localparam int COUNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  typedef struct packed {
    logic                        found;
    logic [COORD_W-1:0]          x;
    logic [COORD_W-1:0]          y;
    logic signed [FEATURE_W-1:0] score;
    logic [COUNT_W-1:0]          count;
  } corner_result_t;

endpackage

// File: rtl/harris_peak_finder_if.sv
// rtl/harris_peak_finder_if.sv - per-frame corner result bus with valid/ready handshake
interface harris_peak_finder_if;
  import harris_pkg::*;

  logic                        result_valid;
  logic                        result_ready;
  logic                        corner_found;
  logic [COORD_W-1:0]          corner_x;
  logic [COORD_W-1:0]          corner_y;
  logic signed [FEATURE_W-1:0] corner_score;
  logic [COUNT_W-1:0]          corner_count;

  modport master (
    output result_valid, corner_found, corner_x, corner_y, corner_score, corner_count,
    input  result_ready
  );

  modport slave (
    input  result_valid, corner_found, corner_x, corner_y, corner_score, corner_count,
    output result_ready
  );

endinterface

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster position of the current pixel with sof resync and end-of-frame flag
module raster_counter
  import harris_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               sof,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

  // x_cnt/y_cnt hold the position expected for the next strobed pixel
  logic [COORD_W-1:0] x_cnt;
  logic [COORD_W-1:0] y_cnt;

  // A sof pixel is (0,0) regardless of where the counters had drifted to
  always_comb begin
    pix_x    = sof ? '0 : x_cnt;
    pix_y    = sof ? '0 : y_cnt;
    pix_last = (pix_x == X_MAX) && (pix_y == Y_MAX);
  end

  // Advance one position per strobed pixel, wrapping at line and frame ends
  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (clk_en) begin
      if (pix_x == X_MAX) begin
        x_cnt <= '0;
        y_cnt <= (pix_y == Y_MAX) ? '0 : pix_y + 1'b1;
      end else begin
        x_cnt <= pix_x + 1'b1;
        y_cnt <= pix_y;
      end
    end
  end

endmodule

// File: rtl/harris_peak_finder.sv
// rtl/harris_peak_finder.sv - per-frame strongest thresholded Harris response outside the image border
module harris_peak_finder
  import harris_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LAT_X    = 2,
  parameter int LAT_Y    = 2,
  parameter int BORDER   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        sof,
  input  logic signed [FEATURE_W-1:0] harris_feature,
  input  logic signed [FEATURE_W-1:0] threshold,
  harris_peak_finder_if.master        res,
  output logic                        overrun
);

  localparam logic signed [10:0] LX    = 11'(LAT_X);
  localparam logic signed [10:0] LY    = 11'(LAT_Y);
  localparam logic signed [10:0] CX_LO = 11'(BORDER);
  localparam logic signed [10:0] CX_HI = 11'(H_ACTIVE - BORDER);
  localparam logic signed [10:0] CY_LO = 11'(BORDER);
  localparam logic signed [10:0] CY_HI = 11'(V_ACTIVE - BORDER);

  logic [COORD_W-1:0] cnt_x;
  logic [COORD_W-1:0] cnt_y;
  logic               cnt_last;

  raster_counter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_raster (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .sof      (sof),
    .pix_x    (cnt_x),
    .pix_y    (cnt_y),
    .pix_last (cnt_last)
  );

  logic                        pix_v;
  logic                        pix_sof;
  logic                        pix_last;
  logic [COORD_W-1:0]          pix_x;
  logic [COORD_W-1:0]          pix_y;
  logic signed [FEATURE_W-1:0] pix_feat;

  // Input stage: capture one strobed pixel; pix_v pulses for a single cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_v    <= 1'b0;
      pix_sof  <= 1'b0;
      pix_last <= 1'b0;
      pix_x    <= '0;
      pix_y    <= '0;
      pix_feat <= '0;
    end else begin
      pix_v   <= clk_en;
      pix_sof <= clk_en & sof;
      if (clk_en) begin
        pix_x    <= cnt_x;
        pix_y    <= cnt_y;
        pix_last <= cnt_last;
        pix_feat <= harris_feature;
      end
    end
  end

  // Raster position minus pipeline latency gives the centre pixel; may go negative
  logic signed [10:0] cx;
  logic signed [10:0] cy;
  logic               eligible;

  assign cx = $signed({1'b0, pix_x}) - LX;
  assign cy = $signed({1'b0, pix_y}) - LY;
  assign eligible = (cx >= CX_LO) && (cx < CX_HI) &&
                    (cy >= CY_LO) && (cy < CY_HI) &&
                    (pix_feat > threshold);

  state_t         state;
  state_t         state_nx;
  corner_result_t acc;
  corner_result_t acc_base;
  corner_result_t acc_nx;
  logic           take;
  logic           publish;

  // Next-state and accumulator update; a sof always restarts with that pixel included
  always_comb begin
    state_nx = state;
    acc_base = acc;
    take     = 1'b0;
    publish  = 1'b0;

    if (pix_v && pix_sof) begin
      state_nx = SCAN;
      acc_base = '0;
      take     = 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        SCAN: begin
          if (pix_v) begin
            take = 1'b1;
            if (pix_last) state_nx = PUBLISH;
          end
        end
        PUBLISH: begin
          publish  = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end

    acc_nx = acc_base;
    if (take && eligible) begin
      if (acc_base.count != '1) acc_nx.count = acc_base.count + 1'b1;
      // Strictly greater keeps the earliest pixel on ties
      if (!acc_base.found || (pix_feat > $signed(acc_base.score))) begin
        acc_nx.found = 1'b1;
        acc_nx.x     = cx[COORD_W-1:0];
        acc_nx.y     = cy[COORD_W-1:0];
        acc_nx.score = pix_feat;
      end
    end
  end

  // State register and frame accumulators
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
    end
  end

  corner_result_t res_q;
  logic           valid_q;

  // Result registers: a publish always loads; unaccepted results are overwritten and flagged
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q   <= '0;
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else if (publish) begin
      res_q   <= acc;
      valid_q <= 1'b1;
      if (valid_q && !res.result_ready) overrun <= 1'b1;
    end else if (valid_q && res.result_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign res.result_valid = valid_q;
  assign res.corner_found = res_q.found;
  assign res.corner_x     = res_q.x;
  assign res.corner_y     = res_q.y;
  assign res.corner_score = res_q.score;
  assign res.corner_count = res_q.count;

endmodule

// File: tb/tb_harris_peak_finder.sv
// tb/tb_harris_peak_finder.sv - directed self-checking bench for harris_peak_finder
module tb_harris_peak_finder;
  import harris_pkg::*;

  localparam int H = 64;
  localparam int V = 48;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        clk_en;
  logic                        sof;
  logic signed [FEATURE_W-1:0] harris_feature;
  logic signed [FEATURE_W-1:0] threshold;
  logic                        overrun;

  harris_peak_finder_if rif();

  harris_peak_finder #(
    .H_ACTIVE(H),
    .V_ACTIVE(V)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .sof            (sof),
    .harris_feature (harris_feature),
    .threshold      (threshold),
    .res            (rif.master),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic signed [FEATURE_W-1:0] bg;
  logic signed [FEATURE_W-1:0] pk_v [2];
  int                          pk_x [2];
  int                          pk_y [2];
  int                          n_pk;

  function automatic logic signed [FEATURE_W-1:0] feat(input int x, input int y);
    feat = bg;
    for (int k = 0; k < n_pk; k++)
      if (x == pk_x[k] && y == pk_y[k]) feat = pk_v[k];
  endfunction

  // Drives n pixels in raster order starting with a sof, then one idle pixel
  task automatic drive_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sof            = (i == 0);
      harris_feature = feat(i % H, i / H);
    end
    @(negedge clk);
    sof            = 1'b0;
    harris_feature = '0;
  endtask

  task automatic wait_result(input string name);
    int t;
    t = 0;
    while (rif.result_valid !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (rif.result_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_valid_timeout: got %b expected 1", name, rif.result_valid);
    end
  endtask

  task automatic accept();
    @(negedge clk);
    rif.result_ready = 1'b1;
    @(negedge clk);
    rif.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; sof = 1'b0; harris_feature = '0;
    threshold = 54'sd100; rif.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    vectors++; if (rif.result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", rif.result_valid); end
    vectors++; if (rif.corner_found !== 1'b0) begin miscompares++; $display("FAIL reset_found: got %b expected 0", rif.corner_found); end
    vectors++; if (rif.corner_x !== 10'd0) begin miscompares++; $display("FAIL reset_x: got %0d expected 0", rif.corner_x); end
    vectors++; if (rif.corner_y !== 10'd0) begin miscompares++; $display("FAIL reset_y: got %0d expected 0", rif.corner_y); end
    vectors++; if (rif.corner_score !== 54'sd0) begin miscompares++; $display("FAIL reset_score: got %0d expected 0", rif.corner_score); end
    vectors++; if (rif.corner_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", rif.corner_count); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_single_peak();
    bg = '0; n_pk = 1; pk_x[0] = 40; pk_y[0] = 20; pk_v[0] = 54'sd5000;
    drive_pixels(H * V);
    @(negedge clk);
    vectors++; if (rif.result_valid !== 1'b0) begin miscompares++; $display("FAIL peak_valid_early: got %b expected 0", rif.result_valid); end
    @(negedge clk);
    vectors++; if (rif.result_valid !== 1'b1) begin miscompares++; $display("FAIL peak_valid_latency: got %b expected 1", rif.result_valid); end
    vectors++; if (rif.corner_found !== 1'b1) begin miscompares++; $display("FAIL peak_found: got %b expected 1", rif.corner_found); end
    vectors++; if (rif.corner_x !== 10'd38) begin miscompares++; $display("FAIL peak_x: got %0d expected 38", rif.corner_x); end
    vectors++; if (rif.corner_y !== 10'd18) begin miscompares++; $display("FAIL peak_y: got %0d expected 18", rif.corner_y); end
    vectors++; if (rif.corner_score !== 54'sd5000) begin miscompares++; $display("FAIL peak_score: got %0d expected 5000", rif.corner_score); end
    vectors++; if (rif.corner_count !== 16'd1) begin miscompares++; $display("FAIL peak_count: got %0d expected 1", rif.corner_count); end
    accept();
  endtask

  task automatic test_tie();
    bg = '0; n_pk = 2;
    pk_x[0] = 12; pk_y[0] = 10; pk_v[0] = 54'sd700;
    pk_x[1] = 30; pk_y[1] = 10; pk_v[1] = 54'sd700;
    drive_pixels(H * V);
    wait_result("tie");
    vectors++; if (rif.corner_x !== 10'd10) begin miscompares++; $display("FAIL tie_x: got %0d expected 10", rif.corner_x); end
    vectors++; if (rif.corner_y !== 10'd8) begin miscompares++; $display("FAIL tie_y: got %0d expected 8", rif.corner_y); end
    vectors++; if (rif.corner_score !== 54'sd700) begin miscompares++; $display("FAIL tie_score: got %0d expected 700", rif.corner_score); end
    vectors++; if (rif.corner_count !== 16'd2) begin miscompares++; $display("FAIL tie_count: got %0d expected 2", rif.corner_count); end
    accept();
  endtask

  task automatic test_signed();
    bg = -54'sd5; n_pk = 0; threshold = -54'sd20;
    drive_pixels(H * V);
    wait_result("signed");
    vectors++; if (rif.corner_found !== 1'b1) begin miscompares++; $display("FAIL signed_found: got %b expected 1", rif.corner_found); end
    vectors++; if (rif.corner_count !== 16'd2436) begin miscompares++; $display("FAIL signed_count: got %0d expected 2436", rif.corner_count); end
    vectors++; if (rif.corner_x !== 10'd3) begin miscompares++; $display("FAIL signed_x: got %0d expected 3", rif.corner_x); end
    vectors++; if (rif.corner_y !== 10'd3) begin miscompares++; $display("FAIL signed_y: got %0d expected 3", rif.corner_y); end
    vectors++; if (rif.corner_score !== -54'sd5) begin miscompares++; $display("FAIL signed_score: got %0d expected -5", rif.corner_score); end
    threshold = 54'sd100;
    accept();
  endtask

  task automatic test_empty();
    bg = 54'sd100; n_pk = 0;
    drive_pixels(H * V);
    wait_result("empty");
    vectors++; if (rif.corner_found !== 1'b0) begin miscompares++; $display("FAIL empty_found: got %b expected 0", rif.corner_found); end
    vectors++; if (rif.corner_x !== 10'd0) begin miscompares++; $display("FAIL empty_x: got %0d expected 0", rif.corner_x); end
    vectors++; if (rif.corner_y !== 10'd0) begin miscompares++; $display("FAIL empty_y: got %0d expected 0", rif.corner_y); end
    vectors++; if (rif.corner_score !== 54'sd0) begin miscompares++; $display("FAIL empty_score: got %0d expected 0", rif.corner_score); end
    vectors++; if (rif.corner_count !== 16'd0) begin miscompares++; $display("FAIL empty_count: got %0d expected 0", rif.corner_count); end
    accept();
  endtask

  task automatic test_border();
    bg = 54'sd50; n_pk = 1; pk_x[0] = 4; pk_y[0] = 4; pk_v[0] = 54'sd9000;
    drive_pixels(H * V);
    wait_result("border");
    vectors++; if (rif.corner_found !== 1'b0) begin miscompares++; $display("FAIL border_found: got %b expected 0", rif.corner_found); end
    vectors++; if (rif.corner_count !== 16'd0) begin miscompares++; $display("FAIL border_count: got %0d expected 0", rif.corner_count); end
    accept();
  endtask

  task automatic test_sof_abort();
    bg = '0; n_pk = 1; pk_x[0] = 20; pk_y[0] = 5; pk_v[0] = 54'sd8000;
    drive_pixels(30 * H + 10);
    vectors++; if (rif.result_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_publish: got %b expected 0", rif.result_valid); end
    pk_x[0] = 40; pk_y[0] = 20; pk_v[0] = 54'sd600;
    drive_pixels(H * V);
    wait_result("abort");
    vectors++; if (rif.corner_x !== 10'd38) begin miscompares++; $display("FAIL abort_x: got %0d expected 38", rif.corner_x); end
    vectors++; if (rif.corner_y !== 10'd18) begin miscompares++; $display("FAIL abort_y: got %0d expected 18", rif.corner_y); end
    vectors++; if (rif.corner_score !== 54'sd600) begin miscompares++; $display("FAIL abort_score: got %0d expected 600", rif.corner_score); end
    vectors++; if (rif.corner_count !== 16'd1) begin miscompares++; $display("FAIL abort_count: got %0d expected 1", rif.corner_count); end
    accept();
  endtask

  task automatic test_handshake();
    bg = '0; n_pk = 1; pk_x[0] = 40; pk_y[0] = 20; pk_v[0] = 54'sd300;
    drive_pixels(H * V);
    wait_result("hs_first");
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL hs_overrun_early: got %b expected 0", overrun); end
    pk_v[0] = 54'sd400;
    drive_pixels(H * V);
    repeat (2) @(negedge clk);
    vectors++; if (rif.result_valid !== 1'b1) begin miscompares++; $display("FAIL hs_valid_held: got %b expected 1", rif.result_valid); end
    vectors++; if (rif.corner_score !== 54'sd400) begin miscompares++; $display("FAIL hs_score: got %0d expected 400", rif.corner_score); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL hs_overrun: got %b expected 1", overrun); end
    rif.result_ready = 1'b1;
    @(negedge clk);
    rif.result_ready = 1'b0;
    vectors++; if (rif.result_valid !== 1'b0) begin miscompares++; $display("FAIL hs_valid_drop: got %b expected 0", rif.result_valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL hs_overrun_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid_scan();
    bool_seen:
    begin
      logic seen;
      bg = '0; n_pk = 1; pk_x[0] = 20; pk_y[0] = 5; pk_v[0] = 54'sd7000;
      drive_pixels(1000);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++; if (rif.result_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b expected 0", rif.result_valid); end
      vectors++; if (rif.corner_found !== 1'b0) begin miscompares++; $display("FAIL rst_mid_found: got %b expected 0", rif.corner_found); end
      vectors++; if (rif.corner_score !== 54'sd0) begin miscompares++; $display("FAIL rst_mid_score: got %0d expected 0", rif.corner_score); end
      vectors++; if (rif.corner_count !== 16'd0) begin miscompares++; $display("FAIL rst_mid_count: got %0d expected 0", rif.corner_count); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
      seen = 1'b0;
      harris_feature = 54'sd5000;
      for (int i = 0; i < H * V + 100; i++) begin
        @(negedge clk);
        if (rif.result_valid === 1'b1) seen = 1'b1;
      end
      harris_feature = '0;
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_publish: got %b expected 0", seen); end
    end
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_tie();
    test_signed();
    test_empty();
    test_border();
    test_sof_abort();
    test_handshake();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
